// File: rtl/optialu_pkg.sv
// Shared types and widths for the optialu_arb ALU-sharing sequencer.
package optialu_pkg;

    localparam int DATA_W = 32;

    typedef logic [3:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        opcode_t           opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic              bin;
    } cmd_t;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] result;
        logic              cout;
        logic              bout;
    } rsp_t;

endpackage

// File: rtl/optialu_arb_if.sv
// Bundle of the two requester ports, the response port and the shared-ALU port.
interface optialu_arb_if;
    import optialu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    opcode_t           req0_opcode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_cin;
    logic              req0_bin;

    logic              req1_valid;
    logic              req1_ready;
    opcode_t           req1_opcode;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_cin;
    logic              req1_bin;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;
    logic              rsp_bout;

    logic              alu_en;
    opcode_t           alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_cin;
    logic              alu_bin;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              alu_bout;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_cin, req0_bin,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_cin, req1_bin,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_bout,
        input  rsp_ready,
        output alu_en, alu_opcode, alu_a, alu_b, alu_cin, alu_bin,
        input  alu_result, alu_cout, alu_bout
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_cin, req0_bin,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_cin, req1_bin,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_bout,
        output rsp_ready,
        input  alu_en, alu_opcode, alu_a, alu_b, alu_cin, alu_bin,
        output alu_result, alu_cout, alu_bout
    );

endinterface

// File: rtl/optialu_rr_arb.sv
// Two-way arbiter with one-hot grant; round-robin by default,
// fixed priority to requester 0 when OPTIALU_ARB_FIXED_PRIO_EN is defined.
module optialu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef OPTIALU_ARB_FIXED_PRIO_EN

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end
    end

`else

    // prio names the requester that wins a tie: the one not granted last.
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !prio)) grant = 2'b01;
            else if (req[1])                  grant = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio <= 1'b0;
        else if (|grant) prio <= grant[0];
    end

`endif

endmodule

// File: rtl/optialu_arb.sv
// Lets two requesters share one external ALU: grant, hold operands for
// SETTLE_CYCLES, capture the result. Build option: OPTIALU_ARB_FIXED_PRIO_EN.
module optialu_arb
    import optialu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_n,
    optialu_arb_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [1:0] grant;
    logic       owner;
    cmd_t       cmd;
    cmd_t       req_cmd;
    rsp_t       rsp;

    // Gating with rst_n keeps the ready pulses low while reset is held.
    optialu_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .en    ((state == IDLE) && rst_n),
        .grant (grant)
    );

    assign req_cmd = grant[1]
        ? {bus.req1_opcode, bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_bin}
        : {bus.req0_opcode, bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_bin};

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant)           state_nxt = EXEC;
            EXEC:    if (cnt == 4'd1)      state_nxt = RESP;
            RESP:    if (bus.rsp_ready)    state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd   <= '0;
            owner <= 1'b0;
            cnt   <= '0;
            rsp   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cmd   <= req_cmd;
                        owner <= grant[1];
                        cnt   <= 4'(SETTLE_CYCLES);
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        rsp <= '{id: owner, result: bus.alu_result,
                                 cout: bus.alu_cout, bout: bus.alu_bout};
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign bus.alu_en     = (state == EXEC);
    assign bus.alu_opcode = cmd.opcode;
    assign bus.alu_a      = cmd.a;
    assign bus.alu_b      = cmd.b;
    assign bus.alu_cin    = cmd.cin;
    assign bus.alu_bin    = cmd.bin;

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp.id;
    assign bus.rsp_result = rsp.result;
    assign bus.rsp_cout   = rsp.cout;
    assign bus.rsp_bout   = rsp.bout;

endmodule

// File: tb/tb_optialu_arb.sv
// Self-checking bench for optialu_arb: one instance with SETTLE_CYCLES=1, one with 4,
// each driving a behavioural ALU; responses are checked against a queue of expected results.
module tb_optialu_arb;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        cout;
        logic        bout;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t sb1[$];
    exp_t sb4[$];

    optialu_arb_if b1 ();
    optialu_arb_if b4 ();

    optialu_arb #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    optialu_arb #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, returns {bout, cout, result}.
    function automatic logic [33:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                          logic cin, logic bin);
        logic [32:0] t;
        logic [33:0] r;
        r = '0;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b} + 33'(cin); r = {1'b0, t[32], t[31:0]}; end
            4'd1: begin t = {1'b0, a} - {1'b0, b} - 33'(bin); r = {t[32], 1'b0, t[31:0]}; end
            4'd2: r[31:0] = a & b;
            4'd3: r[31:0] = a | b;
            4'd4: r[31:0] = a ^ b;
            default: r[31:0] = a;
        endcase
        return r;
    endfunction

    function automatic exp_t mk_exp(logic id, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                    logic cin, logic bin);
        logic [33:0] r;
        r = alu_f(op, a, b, cin, bin);
        return '{id: id, result: r[31:0], cout: r[32], bout: r[33]};
    endfunction

    assign {b1.alu_bout, b1.alu_cout, b1.alu_result} =
        alu_f(b1.alu_opcode, b1.alu_a, b1.alu_b, b1.alu_cin, b1.alu_bin);
    assign {b4.alu_bout, b4.alu_cout, b4.alu_result} =
        alu_f(b4.alu_opcode, b4.alu_a, b4.alu_b, b4.alu_cin, b4.alu_bin);

    exp_t got1;
    exp_t got4;
    assign got1 = {b1.rsp_id, b1.rsp_result, b1.rsp_cout, b1.rsp_bout};
    assign got4 = {b4.rsp_id, b4.rsp_result, b4.rsp_cout, b4.rsp_bout};

    logic [108:0] outs1;
    logic [108:0] outs4;
    assign outs1 = {b1.req0_ready, b1.req1_ready, b1.rsp_valid, b1.rsp_id, b1.rsp_result,
                    b1.rsp_cout, b1.rsp_bout, b1.alu_en, b1.alu_opcode, b1.alu_a, b1.alu_b,
                    b1.alu_cin, b1.alu_bin};
    assign outs4 = {b4.req0_ready, b4.req1_ready, b4.rsp_valid, b4.rsp_id, b4.rsp_result,
                    b4.rsp_cout, b4.rsp_bout, b4.alu_en, b4.alu_opcode, b4.alu_a, b4.alu_b,
                    b4.alu_cin, b4.alu_bin};

    task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic bin);
        if (n == 0) begin
            b1.req0_opcode = op; b1.req0_a = a; b1.req0_b = b; b1.req0_cin = cin; b1.req0_bin = bin;
        end else begin
            b1.req1_opcode = op; b1.req1_a = a; b1.req1_b = b; b1.req1_cin = cin; b1.req1_bin = bin;
        end
    endtask

    task automatic pop1(output exp_t e, output bit ok);
        ok = (sb1.size() > 0);
        e  = '0;
        if (ok) e = sb1.pop_front();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb1.delete();
        sb4.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b1.req0_valid = 1'b1;
        b1.req1_valid = 1'b1;
        b4.req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (outs1 !== '0) begin n_err++; $display("FAIL reset_outs1: got %h expected 0", outs1); end
        n_chk++;
        if (outs4 !== '0) begin n_err++; $display("FAIL reset_outs4: got %h expected 0", outs4); end
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        b4.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok;
        b1.rsp_ready = 1'b1;
        set_req(0, 4'd0, 32'd10, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        b1.req0_valid = 1'b1;
        #1;
        n_chk++;
        if ({b1.req0_ready, b1.req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL single_grant: got %b expected 10", {b1.req0_ready, b1.req1_ready});
        end
        sb1.push_back(mk_exp(1'b0, 4'd0, 32'd10, 32'd5, 1'b0, 1'b0));
        @(negedge clk);
        b1.req0_valid = 1'b0;
        #1;
        n_chk++;
        if ({b1.alu_en, b1.alu_opcode, b1.alu_a, b1.alu_b, b1.req0_ready, b1.req1_ready} !==
            {1'b1, 4'd0, 32'd10, 32'd5, 2'b00}) begin
            n_err++; $display("FAIL single_exec: got en=%b op=%0d a=%0d b=%0d expected en=1 op=0 a=10 b=5",
                              b1.alu_en, b1.alu_opcode, b1.alu_a, b1.alu_b);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (b1.rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL single_latency: rsp_valid got %b expected 1 two cycles after ready", b1.rsp_valid);
        end
        pop1(e, ok);
        n_chk++;
        if (!ok || got1 !== e) begin
            n_err++; $display("FAIL single_rsp: got %h expected %h (queued=%0d)", got1, e, ok);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({b1.rsp_valid, b1.alu_en, b1.alu_a, b1.alu_b} !== {1'b0, 1'b0, 32'd10, 32'd5}) begin
            n_err++; $display("FAIL single_idle_hold: got valid=%b en=%b a=%0d b=%0d expected 0 0 10 5",
                              b1.rsp_valid, b1.alu_en, b1.alu_a, b1.alu_b);
        end
    endtask

    task automatic test_round_robin();
        logic exp_ids [4];
        int   gcyc [4];
        int   grants;
        int   rsps;
        int   bad;
        logic id;
        exp_t e;
        bit   ok;
`ifdef OPTIALU_ARB_FIXED_PRIO_EN
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        grants = 0;
        rsps   = 0;
        bad    = 0;
        do_reset();
        b1.rsp_ready = 1'b1;
        set_req(0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
        set_req(1, 4'd1, 32'd3, 32'd5, 1'b0, 1'b1);
        @(negedge clk);
        b1.req0_valid = 1'b1;
        b1.req1_valid = 1'b1;
        for (int c = 0; c < 40 && (grants < 4 || rsps < 4); c++) begin
            #1;
            if ((b1.req0_ready && b1.req1_ready) ||
                ((b1.req0_ready || b1.req1_ready) && (b1.alu_en || b1.rsp_valid))) bad++;
            if ((b1.req0_ready || b1.req1_ready) && grants < 4) begin
                id = b1.req1_ready;
                n_chk++;
                if (id !== exp_ids[grants]) begin
                    n_err++; $display("FAIL rr_grant%0d: got requester %0d expected %0d", grants, id, exp_ids[grants]);
                end
                if (id) sb1.push_back(mk_exp(1'b1, 4'd1, 32'd3, 32'd5, 1'b0, 1'b1));
                else    sb1.push_back(mk_exp(1'b0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0));
                gcyc[grants] = c;
                grants++;
            end
            if (b1.rsp_valid) begin
                pop1(e, ok);
                n_chk++;
                if (!ok || got1 !== e) begin
                    n_err++; $display("FAIL rr_rsp%0d: got %h expected %h (queued=%0d)", rsps, got1, e, ok);
                end
                rsps++;
            end
            @(negedge clk);
        end
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        n_chk++;
        if (grants != 4 || rsps != 4) begin
            n_err++; $display("FAIL rr_timeout: got grants=%0d rsps=%0d expected 4 and 4", grants, rsps);
        end
        for (int i = 1; i < grants; i++) begin
            n_chk++;
            if (gcyc[i] - gcyc[i-1] != 3) begin
                n_err++; $display("FAIL rr_gap%0d: got %0d cycles between grants expected 3", i, gcyc[i] - gcyc[i-1]);
            end
        end
        n_chk++;
        if (bad != 0) begin
            n_err++; $display("FAIL rr_ready_rules: got %0d illegal ready cycles expected 0", bad);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        b1.rsp_ready = 1'b0;
        set_req(1, 4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 1'b0);
        set_req(0, 4'd3, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);
        @(negedge clk);
        b1.req1_valid = 1'b1;
        #1;
        n_chk++;
        if ({b1.req0_ready, b1.req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_grant: got %b expected 01", {b1.req0_ready, b1.req1_ready});
        end
        sb1.push_back(mk_exp(1'b1, 4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 1'b0));
        @(negedge clk);
        b1.req1_valid = 1'b0;
        b1.req0_valid = 1'b1;
        #1;
        n_chk++;
        if ({b1.req0_ready, b1.req1_ready, b1.alu_en} !== 3'b001) begin
            n_err++; $display("FAIL bp_exec: got ready=%b en=%b expected ready=00 en=1",
                              {b1.req0_ready, b1.req1_ready}, b1.alu_en);
        end
        @(negedge clk);
        #1;
        pop1(e, ok);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            n_chk++;
            if (!ok || {b1.rsp_valid, got1, b1.req0_ready, b1.req1_ready} !== {1'b1, e, 2'b00}) begin
                n_err++; $display("FAIL bp_stall%0d: got valid=%b rsp=%h ready=%b expected valid=1 rsp=%h ready=00",
                                  i, b1.rsp_valid, got1, {b1.req0_ready, b1.req1_ready}, e);
            end
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_chk++;
        if ({b1.rsp_valid, b1.req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_release: got valid=%b ready0=%b expected valid=0 ready0=1",
                              b1.rsp_valid, b1.req0_ready);
        end
        sb1.push_back(mk_exp(1'b0, 4'd3, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0));
        @(negedge clk);
        b1.req0_valid = 1'b0;
        @(negedge clk);
        #1;
        pop1(e, ok);
        n_chk++;
        if (!ok || b1.rsp_valid !== 1'b1 || got1 !== e) begin
            n_err++; $display("FAIL bp_next_rsp: got valid=%b rsp=%h expected valid=1 rsp=%h", b1.rsp_valid, got1, e);
        end
    endtask

    task automatic test_settle4();
        int   en_cnt;
        int   lat;
        int   bad_in;
        exp_t e;
        bit   ok;
        en_cnt = 0;
        lat    = 0;
        bad_in = 0;
        b4.rsp_ready   = 1'b1;
        b4.req0_opcode = 4'd0;
        b4.req0_a      = 32'd10000;
        b4.req0_b      = 32'd123;
        b4.req0_cin    = 1'b1;
        b4.req0_bin    = 1'b0;
        @(negedge clk);
        b4.req0_valid = 1'b1;
        #1;
        n_chk++;
        if (b4.req0_ready !== 1'b1) begin
            n_err++; $display("FAIL settle_grant: got ready0=%b expected 1", b4.req0_ready);
        end
        sb4.push_back(mk_exp(1'b0, 4'd0, 32'd10000, 32'd123, 1'b1, 1'b0));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) b4.req0_valid = 1'b0;
            #1;
            if (b4.alu_en) begin
                en_cnt++;
                if ({b4.alu_opcode, b4.alu_a, b4.alu_b, b4.alu_cin, b4.alu_bin} !==
                    {4'd0, 32'd10000, 32'd123, 1'b1, 1'b0}) bad_in++;
            end
            if (b4.rsp_valid && lat == 0) begin
                lat = c;
                ok  = (sb4.size() > 0);
                e   = '0;
                if (ok) e = sb4.pop_front();
                n_chk++;
                if (!ok || got4 !== e) begin
                    n_err++; $display("FAIL settle_rsp: got %h expected %h (queued=%0d)", got4, e, ok);
                end
            end
        end
        n_chk++;
        if (en_cnt != 4) begin n_err++; $display("FAIL settle_en_cycles: got %0d expected 4", en_cnt); end
        n_chk++;
        if (lat != 5) begin n_err++; $display("FAIL settle_latency: got %0d expected 5", lat); end
        n_chk++;
        if (bad_in != 0) begin n_err++; $display("FAIL settle_alu_inputs: got %0d bad cycles expected 0", bad_in); end
    endtask

    task automatic test_reset_mid();
        int   seen;
        int   lat;
        exp_t e;
        bit   ok;
        seen = 0;
        lat  = 0;
        b1.rsp_ready = 1'b1;
        set_req(0, 4'd0, 32'd7, 32'd8, 1'b1, 1'b0);
        @(negedge clk);
        b1.req0_valid = 1'b1;
        #1;
        @(negedge clk);
        b1.req0_valid = 1'b0;
        #1;
        n_chk++;
        if (b1.alu_en !== 1'b1) begin n_err++; $display("FAIL midrst_exec: got alu_en=%b expected 1", b1.alu_en); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (outs1 !== '0) begin n_err++; $display("FAIL midrst_outs1: got %h expected 0", outs1); end
        n_chk++;
        if (outs4 !== '0) begin n_err++; $display("FAIL midrst_outs4: got %h expected 0", outs4); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (b1.rsp_valid) seen++;
        end
        n_chk++;
        if (seen != 0) begin n_err++; $display("FAIL midrst_abandon: got %0d rsp cycles expected 0", seen); end
        set_req(1, 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0);
        @(negedge clk);
        b1.req1_valid = 1'b1;
        #1;
        n_chk++;
        if ({b1.req0_ready, b1.req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL midrst_grant1: got %b expected 01", {b1.req0_ready, b1.req1_ready});
        end
        sb1.push_back(mk_exp(1'b1, 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0));
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) b1.req1_valid = 1'b0;
            #1;
            if (b1.rsp_valid) begin
                lat = c;
                pop1(e, ok);
                n_chk++;
                if (!ok || got1 !== e) begin
                    n_err++; $display("FAIL midrst_rsp: got %h expected %h (queued=%0d)", got1, e, ok);
                end
            end
        end
        n_chk++;
        if (lat != 2) begin n_err++; $display("FAIL midrst_latency: got %0d expected 2", lat); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        {b1.req0_valid, b1.req1_valid, b1.rsp_ready, b4.req0_valid, b4.req1_valid, b4.rsp_ready} = '0;
        set_req(0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_req(1, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        {b4.req0_opcode, b4.req0_a, b4.req0_b, b4.req0_cin, b4.req0_bin} = '0;
        {b4.req1_opcode, b4.req1_a, b4.req1_b, b4.req1_cin, b4.req1_bin} = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_settle4();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
